block_plot_datapath: RTL

BLOCK_PLOT_DATAPATH -- requirements
Module: block_plot_datapath

---
 rtl/block_plot_datapath.sv | 120 ++++++++++++
 1 files changed

// File: rtl/block_plot_datapath.sv
// Datapath for a moving BLOCK_W x BLOCK_H block: position/direction registers plus a row-major pixel sweep.
// Optional feature: define BLOCK_BOUNCE_EN to bounce off the right edge instead of wrapping to column 0.
module block_plot_datapath #(
    parameter int          BLOCK_W = 4,
    parameter int          BLOCK_H = 4,
    parameter int          X_MAX   = 159,
    parameter int          Y_START = 116,
    parameter logic [2:0]  COLOUR  = 3'b111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ld_x,
    input  logic       ld_y,
    input  logic       count_x_enable,
    input  logic       colour_erase_enable,
    input  logic       reset_load,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       done_plot
);

    localparam logic [3:0] CX_LAST = 4'(BLOCK_W - 1);
    localparam logic [3:0] CY_LAST = 4'(BLOCK_H - 1);
    localparam logic [7:0] X_EDGE  = 8'(X_MAX - BLOCK_W + 1);
    localparam logic [6:0] Y_RST   = 7'(Y_START);
    localparam logic [6:0] Y_STEP  = 7'(BLOCK_H);

    logic [7:0] x_pos;
    logic [6:0] y_pos;
    logic       dir;
    logic [3:0] cnt_x;
    logic [3:0] cnt_y;
    logic       done_q;

    logic       last_px;
    logic       at_right;
    logic       at_left;
    logic [7:0] x_step;
    logic       dir_step;
    logic [6:0] y_up;
    logic [3:0] cnt_x_nxt;
    logic [3:0] cnt_y_nxt;

    assign last_px  = (cnt_x == CX_LAST) && (cnt_y == CY_LAST);
    assign at_right = !dir && (x_pos == X_EDGE);
    assign at_left  = dir && (x_pos == 8'd0);

    // Horizontal step target, including edge handling.
    always_comb begin
        x_step   = x_pos + 8'd1;
        dir_step = dir;
        if (at_right) begin
`ifdef BLOCK_BOUNCE_EN
            x_step   = x_pos - 8'd1;
            dir_step = 1'b1;
`else
            x_step   = 8'd0;
            dir_step = 1'b0;
`endif
        end else if (at_left) begin
            x_step   = 8'd1;
            dir_step = 1'b0;
        end else if (dir) begin
            x_step   = x_pos - 8'd1;
        end
    end

    // Row step saturates at the top of the screen.
    assign y_up = (y_pos >= Y_STEP) ? (y_pos - Y_STEP) : 7'd0;

    always_comb begin
        cnt_x_nxt = cnt_x + 4'd1;
        cnt_y_nxt = cnt_y;
        if (cnt_x == CX_LAST) begin
            cnt_x_nxt = 4'd0;
            cnt_y_nxt = (cnt_y == CY_LAST) ? 4'd0 : cnt_y + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !reset_load) begin
            x_pos  <= 8'd0;
            y_pos  <= Y_RST;
            dir    <= 1'b0;
            cnt_x  <= 4'd0;
            cnt_y  <= 4'd0;
            done_q <= 1'b0;
        end else if (ld_x) begin
            x_pos  <= x_step;
            dir    <= dir_step;
            cnt_x  <= 4'd0;
            cnt_y  <= 4'd0;
            done_q <= 1'b0;
        end else if (ld_y) begin
            x_pos  <= 8'd0;
            y_pos  <= y_up;
            dir    <= 1'b0;
            cnt_x  <= 4'd0;
            cnt_y  <= 4'd0;
            done_q <= 1'b0;
        end else begin
            // done_q is a one-cycle pulse; counters already wrapped and hold during it.
            done_q <= 1'b0;
            if (count_x_enable && !done_q) begin
                cnt_x  <= cnt_x_nxt;
                cnt_y  <= cnt_y_nxt;
                done_q <= last_px;
            end
        end
    end

    assign x         = x_pos + {4'd0, cnt_x};
    assign y         = y_pos + {3'd0, cnt_y};
    assign colour    = colour_erase_enable ? 3'b000 : COLOUR;
    assign plot      = count_x_enable && !done_q;
    assign done_plot = done_q;

endmodule
